// File: rtl/trace_buffer.sv
// Retirement trace buffer: a circular record store that captures around a PC-match
// or forced trigger, then drains the captured window oldest-first over a ready/valid port.
module trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4,
  parameter int STOP_CYCLES = 2048,
  parameter int CYC_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        trig_en,
  input  logic [31:0]                 trig_pc,
  input  logic                        retire_valid,
  input  logic [31:0]                 retire_pc,
  input  logic [4:0]                  retire_rd,
  input  logic [31:0]                 retire_rd_data,
  input  logic                        retire_branch,
  input  logic                        retire_taken,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [71+CYC_W-1:0]         rd_data,
  output logic [1:0]                  state,
  output logic                        triggered,
  output logic                        timed_out,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);
  // Record holds timestamp, pc, rd, rd_data, branch and taken: 71 + CYC_W bits.
  localparam int RW = 71 + CYC_W;
  localparam logic [1:0] IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11;

  logic [RW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr, wptrNext, rptrNext, postCnt, postNext;
  logic [AW:0]      countNext;
  logic [CYC_W-1:0] cyc, cycNext;
  logic [1:0]       stateNext;
  logic             trigNext, toNext, wrEn, pcHit, tmo;
  logic [RW-1:0]    rec, rdNext;

  assign rec   = {cyc, retire_pc, retire_rd, retire_rd_data, retire_branch, retire_taken};
  assign wrEn  = !arm && retire_valid && (state == ARMED || state == POST);
  assign pcHit = retire_valid && trig_en && (retire_pc == trig_pc);
  assign tmo   = (STOP_CYCLES != 0) && (cyc == CYC_W'(STOP_CYCLES - 1));

  always_comb begin
    stateNext = state;
    countNext = count;
    wptrNext  = wptr;
    postNext  = postCnt;
    trigNext  = triggered;
    toNext    = timed_out;
    cycNext   = cyc;
    if (arm) begin
      stateNext = ARMED;
      countNext = '0;
      wptrNext  = '0;
      cycNext   = '0;
      trigNext  = 1'b0;
      toNext    = 1'b0;
    end else begin
      case (state)
        ARMED, POST: begin
          if (cyc != '1) cycNext = cyc + 1'b1;
          if (retire_valid) begin
            wptrNext = wptr + 1'b1;
            if (count != (AW+1)'(DEPTH)) countNext = count + 1'b1;
          end
          // A PC match wins over a coincident timeout, so timed_out stays low then.
          if (state == ARMED && (pcHit || tmo)) begin
            trigNext = 1'b1;
            toNext   = !pcHit;
            if (POST_TRIG == 0) stateNext = DONE;
            else begin
              stateNext = POST;
              postNext  = AW'(POST_TRIG);
            end
          end else if (state == POST && retire_valid) begin
            postNext = postCnt - 1'b1;
            if (postCnt == AW'(1)) stateNext = DONE;
          end
        end
        DONE: begin
          if (rd_valid && rd_ready) countNext = count - 1'b1;
        end
        default: ;
      endcase
      if (stateNext == DONE && countNext == '0) stateNext = IDLE;
    end
  end

  // Oldest record sits count entries behind the write pointer; forward a same-cycle write.
  always_comb begin
    rptrNext = wptrNext - countNext[AW-1:0];
    rdNext   = (wrEn && wptr == rptrNext) ? rec : mem[rptrNext];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      wptr      <= '0;
      cyc       <= '0;
      postCnt   <= '0;
      triggered <= 1'b0;
      timed_out <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state     <= stateNext;
      count     <= countNext;
      wptr      <= wptrNext;
      cyc       <= cycNext;
      postCnt   <= postNext;
      triggered <= trigNext;
      timed_out <= toNext;
      rd_valid  <= (stateNext == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn && !rst) mem[wptr] <= rec;
    rd_data <= rdNext;
  end
endmodule

// File: tb/tb_trace_buffer.sv
// Self-checking bench for trace_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_trace_buffer;
  localparam int DEPTH = 8, POST_TRIG = 2, STOP_CYCLES = 16, CYC_W = 16;
  localparam int RW = 71 + CYC_W;

  logic clk = 1'b0;
  logic rst, arm, trig_en, retire_valid, retire_branch, retire_taken, rd_ready;
  logic [31:0] trig_pc, retire_pc, retire_rd_data;
  logic [4:0]  retire_rd;
  logic        rd_valid, triggered, timed_out;
  logic [RW-1:0] rd_data;
  logic [1:0]  state;
  logic [3:0]  count;

  int checks = 0, failures = 0;

  // reference model: captured window as a queue, oldest at front
  logic [RW-1:0] mq[$];
  int  ms, mcyc, mpost;
  bit  mtrig, mto;

  trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .STOP_CYCLES(STOP_CYCLES), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_rd(retire_rd),
    .retire_rd_data(retire_rd_data), .retire_branch(retire_branch), .retire_taken(retire_taken),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .triggered(triggered), .timed_out(timed_out), .count(count)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit hit, tmo;
    if (rst || arm) begin
      ms = rst ? 0 : 1;
      mq.delete();
      mcyc = 0; mtrig = 0; mto = 0;
    end else if (ms == 1 || ms == 2) begin
      hit = retire_valid && trig_en && (retire_pc == trig_pc);
      tmo = (mcyc == STOP_CYCLES - 1);
      if (retire_valid) begin
        mq.push_back({CYC_W'(mcyc), retire_pc, retire_rd, retire_rd_data, retire_branch, retire_taken});
        if (mq.size() > DEPTH) void'(mq.pop_front());
      end
      if (mcyc < (1 << CYC_W) - 1) mcyc++;
      if (ms == 1 && (hit || tmo)) begin
        mtrig = 1; mto = !hit; ms = 2; mpost = POST_TRIG;
      end else if (ms == 2 && retire_valid) begin
        mpost--;
        if (mpost == 0) ms = 3;
      end
      if (ms == 3 && mq.size() == 0) ms = 0;
    end else if (ms == 3) begin
      if (rd_ready && mq.size() > 0) void'(mq.pop_front());
      if (mq.size() == 0) ms = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_retire(input logic [31:0] pc);
    retire_valid   = 1'b1;
    retire_pc      = pc;
    retire_rd      = 5'($urandom);
    retire_rd_data = $urandom;
    retire_branch  = 1'($urandom);
    retire_taken   = 1'($urandom);
  endtask

  task automatic do_arm(input logic [31:0] tpc, input logic ten);
    trig_pc = tpc; trig_en = ten; rd_ready = 1'b0; retire_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({state, count, rd_valid, triggered, timed_out} !== {2'b00, 4'd0, 3'b000}) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", {state, count, rd_valid, triggered, timed_out}, 9'h0);
    end
  endtask

  task automatic test_wrap();
    do_arm(32'h28, 1'b1);
    for (int i = 0; i < 20; i++) begin
      set_retire(32'(4 * i));
      tick();
      if (i == 12) begin
        checks++;
        if ({state, count} !== {2'b11, 4'd8}) begin
          failures++;
          $display("FAIL wrap_done got=%h exp=%h", {state, count}, {2'b11, 4'd8});
        end
      end
    end
    retire_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({rd_valid, rd_data[70:39], rd_data[86:71]} !== {1'b1, 32'(32'h14 + 4 * i), 16'(5 + i)}) begin
        failures++;
        $display("FAIL wrap_read%0d got v=%b pc=%h ts=%0d exp pc=%h ts=%0d", i, rd_valid,
                 rd_data[70:39], rd_data[86:71], 32'h14 + 4 * i, 5 + i);
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if ({state, count, rd_valid, triggered} !== {2'b00, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_idle got=%h", {state, count, rd_valid, triggered});
    end
  endtask

  task automatic test_early_trig();
    do_arm(32'h04, 1'b1);
    for (int i = 0; i < 8; i++) begin set_retire(32'(4 * i)); tick(); end
    retire_valid = 1'b0;
    checks++;
    if ({state, count} !== {2'b11, 4'd4}) begin
      failures++;
      $display("FAIL early_done got=%h exp=%h", {state, count}, {2'b11, 4'd4});
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_data[70:39]} !== {1'b1, 32'(4 * i)}) begin
        failures++;
        $display("FAIL early_read%0d got v=%b pc=%h exp pc=%h", i, rd_valid, rd_data[70:39], 4 * i);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_arm(32'h3C, 1'b0);
    for (int i = 0; i < 20; i++) begin
      set_retire(32'(4 * i));
      tick();
      if (i == 15) begin
        checks++;
        if ({state, triggered, timed_out} !== {2'b10, 1'b1, 1'b1}) begin
          failures++;
          $display("FAIL timeout_trig got=%b exp=%b", {state, triggered, timed_out}, 4'b1011);
        end
      end
      if (i == 17) begin
        checks++;
        if ({state, count, rd_data[86:71]} !== {2'b11, 4'd8, 16'd10}) begin
          failures++;
          $display("FAIL timeout_done got st=%b cnt=%0d ts=%0d exp st=11 cnt=8 ts=10",
                   state, count, rd_data[86:71]);
        end
      end
    end
    retire_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_arm(32'h3C, 1'b1);
    for (int i = 0; i < 18; i++) begin set_retire(32'(4 * i)); tick(); end
    retire_valid = 1'b0;
    checks++;
    if ({state, triggered, timed_out, rd_data[70:39]} !== {2'b11, 1'b1, 1'b0, 32'h28}) begin
      failures++;
      $display("FAIL same_cycle got st=%b trig=%b to=%b pc=%h exp st=11 trig=1 to=0 pc=28",
               state, triggered, timed_out, rd_data[70:39]);
    end
  endtask

  task automatic test_stall_and_arm();
    do_arm(32'h28, 1'b1);
    for (int i = 0; i < 13; i++) begin set_retire(32'(4 * i)); tick(); end
    retire_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({count, rd_data} !== {4'd8, mq[0]} || rd_data[70:39] !== 32'h14) begin
        failures++;
        $display("FAIL stall%0d got cnt=%0d data=%h exp cnt=8 data=%h", i, count, rd_data, mq[0]);
      end
    end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    tick();
    checks++;
    if ({count, rd_data[70:39]} !== {4'd7, 32'h18}) begin
      failures++;
      $display("FAIL stall_pop got cnt=%0d pc=%h exp cnt=7 pc=18", count, rd_data[70:39]);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rd_ready = 1'b0;
    checks++;
    if ({state, count} !== {2'b11, 4'd3}) begin
      failures++;
      $display("FAIL drain3 got=%h exp=%h", {state, count}, {2'b11, 4'd3});
    end
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if ({state, count, triggered, rd_valid} !== {2'b01, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL arm_in_done got=%h exp=%h", {state, count, triggered, rd_valid}, {2'b01, 6'd0});
    end
  endtask

  task automatic test_reset_in_post();
    do_arm(32'h10, 1'b1);
    for (int i = 0; i < 5; i++) begin set_retire(32'(4 * i)); tick(); end
    retire_valid = 1'b0;
    checks++;
    if ({state, count} !== {2'b10, 4'd5}) begin
      failures++;
      $display("FAIL post_setup got=%h exp=%h", {state, count}, {2'b10, 4'd5});
    end
    rst = 1'b1; arm = 1'b1; tick(); rst = 1'b0; arm = 1'b0;
    checks++;
    if ({state, count, rd_valid, triggered, timed_out} !== 9'h0) begin
      failures++;
      $display("FAIL reset_in_post got=%h exp=0", {state, count, rd_valid, triggered, timed_out});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      arm = ($urandom_range(0, 39) == 0);
      trig_en = ($urandom_range(0, 3) != 0);
      if (arm) trig_pc = 32'(4 * $urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) set_retire(32'(4 * $urandom_range(0, 15)));
      else retire_valid = 1'b0;
      rd_ready = 1'($urandom);
      tick();
      checks++;
      if ({state, count, rd_valid, triggered, timed_out} !==
          {2'(ms), 4'(mq.size()), ms == 3, mtrig, mto}) begin
        failures++;
        $display("FAIL rand_status cyc=%0d got=%b exp=%b", n, {state, count, rd_valid, triggered, timed_out},
                 {2'(ms), 4'(mq.size()), ms == 3, mtrig, mto});
      end
      if (ms == 3) begin
        checks++;
        if (rd_data !== mq[0]) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got=%h exp=%h", n, rd_data, mq[0]);
        end
      end
    end
    rst = 1'b0; arm = 1'b0; retire_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    retire_valid = 1'b0; retire_pc = '0; retire_rd = '0; retire_rd_data = '0;
    retire_branch = 1'b0; retire_taken = 1'b0;
    ms = 0; mcyc = 0; mpost = 0; mtrig = 0; mto = 0;
    #1;
    tick(); tick();
    test_reset();
    test_wrap();
    test_early_trig();
    test_timeout();
    test_same_cycle();
    test_stall_and_arm();
    test_reset_in_post();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
